edge_interval_meter: RTL and testbench

EDGE_INTERVAL_METER -- requirements
Module: edge_interval_meter

---
 rtl/edge_meter_pkg.sv | 15 +
 rtl/sync_ff.sv | 25 ++
 rtl/edge_interval_meter.sv | 142 ++++++++++++++
 tb/tb_edge_interval_meter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_meter_pkg.sv
// Shared types and parameter defaults for the edge interval meter.
package edge_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | STAGES'(d);
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/edge_interval_meter.sv
// Measures the clk-cycle span of a number of rising edges on an asynchronous
// input, with saturation, an edge-gap timeout and a one-cycle done pulse.
module edge_interval_meter
  import edge_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic [7:0]       num_edges,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] interval,
  output logic             overflow,
  output logic             timeout
);

  localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic              sync_q;
  logic              prev_q;
  logic              seen_low;
  logic [WARM_W-1:0] warm;
  logic              sample_valid;
  logic              rise;

  state_t            state;
  logic [7:0]        remaining;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  gap_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (sync_q)
  );

  // The synchronizer output only reflects real samples once the reset zeros
  // have shifted out; a rise also needs a genuine low sample first, so a
  // signal already high at reset release never looks like an edge.
  assign sample_valid = (warm == WARM_W'(SYNC_STAGES));
  assign rise         = seen_low & sync_q & ~prev_q;
  assign gap_inc      = gap + GAP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      seen_low <= 1'b0;
      warm     <= '0;
    end else begin
      prev_q <= sync_q;
      if (!sample_valid) begin
        warm <= warm + WARM_W'(1);
      end else if (!sync_q) begin
        seen_low <= 1'b1;
      end
    end
  end

  // NOTE: every register, outputs included, takes the async reset so an
  // aborted measurement leaves no stale result or pending pulse behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      interval  <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      remaining <= '0;
      gap       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            interval  <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
            remaining <= num_edges;
            gap       <= '0;
            busy      <= 1'b1;
            if (num_edges == 8'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ARM;
            end
          end
        end
        ARM: begin
          if (rise) begin
            interval <= '0;
            gap      <= '0;
            state    <= MEASURE;
          end else if (gap_inc == GAP_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            gap <= gap_inc;
          end
        end
        MEASURE: begin
          if (interval == CNT_MAX) begin
            overflow <= 1'b1;
          end else begin
            interval <= interval + CNT_W'(1);
          end
          // An edge landing on the timeout cycle still counts as an edge.
          if (rise) begin
            gap       <= '0;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (gap_inc == GAP_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            gap <= gap_inc;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_interval_meter.sv
// Directed bench for edge_interval_meter: two instances cover the normal,
// timeout (TIMEOUT_CYC=16) and saturation (CNT_W=4) configurations.
module tb_edge_interval_meter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_edges;
  logic        sel;
  logic        sig_a;
  logic        sig_b;
  logic        hold_a;
  int          half_a;

  logic        start_a, start_b;
  logic        busy_a, done_a, overflow_a, timeout_a;
  logic [31:0] interval_a;
  logic        busy_b, done_b, overflow_b, timeout_b;
  logic [3:0]  interval_b;

  logic        busy_m, done_m, overflow_m, timeout_m;
  logic [31:0] interval_m;

  int checks = 0;
  int errors = 0;

  assign start_a    = start & ~sel;
  assign start_b    = start & sel;
  assign busy_m     = sel ? busy_b : busy_a;
  assign done_m     = sel ? done_b : done_a;
  assign overflow_m = sel ? overflow_b : overflow_a;
  assign timeout_m  = sel ? timeout_b : timeout_a;
  assign interval_m = sel ? {28'd0, interval_b} : interval_a;

  edge_interval_meter #(.CNT_W(32), .TIMEOUT_CYC(16), .SYNC_STAGES(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_a),
    .start     (start_a),
    .num_edges (num_edges),
    .busy      (busy_a),
    .done      (done_a),
    .interval  (interval_a),
    .overflow  (overflow_a),
    .timeout   (timeout_a)
  );

  edge_interval_meter #(.CNT_W(4), .TIMEOUT_CYC(1024), .SYNC_STAGES(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_b),
    .start     (start_b),
    .num_edges (num_edges),
    .busy      (busy_b),
    .done      (done_b),
    .interval  (interval_b),
    .overflow  (overflow_b),
    .timeout   (timeout_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signal edges fall 3 time units past a multiple of 10, never on a clk edge.
  initial begin
    sig_a  = 1'b0;
    hold_a = 1'b0;
    half_a = 10;
    #3;
    forever begin
      if (half_a == 0) begin
        #10;
        sig_a = hold_a;
      end else begin
        #(half_a);
        sig_a = ~sig_a;
      end
    end
  end

  initial begin
    sig_b = 1'b0;
    #3;
    forever #100 sig_b = ~sig_b;
  end

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    num_edges = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done_m !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    num_edges = 8'd0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, overflow_a, timeout_a, interval_a} !== 36'd0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0", {busy_a, done_a, overflow_a, timeout_a, interval_a});
    end
    checks++;
    if ({busy_b, done_b, overflow_b, timeout_b, interval_b} !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, overflow_b, timeout_b, interval_b});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_basic;
    int cyc;
    sel = 1'b0;
    half_a = 10;
    repeat (10) @(negedge clk);
    pulse_start(8'd10);
    wait_done(200, cyc);
    checks++;
    if (done_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got %b expected 1 within 200 cycles", done_m);
    end
    checks++;
    if (interval_m !== 32'd20 || overflow_m !== 1'b0 || timeout_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got interval=%0d ovf=%b to=%b expected 20 0 0",
               interval_m, overflow_m, timeout_m);
    end
    @(negedge clk);
    checks++;
    if (done_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: got done=%b busy=%b expected 0 0", done_m, busy_m);
    end
  endtask

  task automatic test_busy_start;
    int cyc;
    int extra;
    sel = 1'b0;
    half_a = 20;
    repeat (10) @(negedge clk);
    pulse_start(8'd5);
    repeat (3) @(negedge clk);
    pulse_start(8'd1);
    wait_done(300, cyc);
    checks++;
    if (done_m !== 1'b1 || interval_m !== 32'd20) begin
      errors++;
      $display("FAIL busy_start_result: got done=%b interval=%0d expected 1 20", done_m, interval_m);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_single_done: got extra_done=%0d busy=%b expected 0 0", extra, busy_m);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    sel = 1'b0;
    half_a = 0;
    hold_a = 1'b0;
    #120;
    repeat (4) @(negedge clk);
    pulse_start(8'd4);
    wait_done(100, cyc);
    checks++;
    if (done_m !== 1'b1 || cyc !== 16) begin
      errors++;
      $display("FAIL timeout_latency: got done=%b cycles=%0d expected 1 16", done_m, cyc);
    end
    checks++;
    if (timeout_m !== 1'b1 || interval_m !== 32'd0 || overflow_m !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: got to=%b interval=%0d ovf=%b expected 1 0 0",
               timeout_m, interval_m, overflow_m);
    end
  endtask

  task automatic test_zero_edges;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre_busy: got %b expected 0", busy_m);
    end
    pulse_start(8'd0);
    checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b1 || interval_m !== 32'd0 || timeout_m !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b interval=%0d to=%b expected 1 1 0 0",
               done_m, busy_m, interval_m, timeout_m);
    end
    // A start presented during the DONE cycle must not launch a new run.
    num_edges = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b expected 0 0", busy_m, done_m);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    sel = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start(8'd1);
    wait_done(200, cyc);
    checks++;
    if (done_m !== 1'b1) begin
      errors++;
      $display("FAIL overflow_done: got %b expected 1 within 200 cycles", done_m);
    end
    checks++;
    if (interval_m !== 32'd15 || overflow_m !== 1'b1 || timeout_m !== 1'b0) begin
      errors++;
      $display("FAIL overflow_result: got interval=%0d ovf=%b to=%b expected 15 1 0",
               interval_m, overflow_m, timeout_m);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    sel = 1'b0;
    half_a = 10;
    #120;
    repeat (4) @(negedge clk);
    pulse_start(8'd10);
    repeat (8) @(negedge clk);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_busy: got %b expected 1", busy_m);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, overflow_a, timeout_a, interval_a} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {busy_a, done_a, overflow_a, timeout_a, interval_a});
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_a === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done_a === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses expected 0", seen);
    end
    pulse_start(8'd6);
    wait_done(200, cyc);
    checks++;
    if (done_m !== 1'b1 || interval_m !== 32'd12 || timeout_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rerun: got done=%b interval=%0d to=%b expected 1 12 0",
               done_m, interval_m, timeout_m);
    end
  endtask

  task automatic test_power_on_high;
    int cyc;
    sel = 1'b0;
    half_a = 0;
    hold_a = 1'b1;
    #120;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    num_edges = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, cyc);
    checks++;
    if (done_m !== 1'b1 || timeout_m !== 1'b1 || interval_m !== 32'd0) begin
      errors++;
      $display("FAIL power_on_high: got done=%b to=%b interval=%0d expected 1 1 0",
               done_m, timeout_m, interval_m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_start();
    test_timeout();
    test_zero_edges();
    test_overflow();
    test_reset_mid();
    test_power_on_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
